// File: rtl/vga_text_pkg.sv
// Shared definitions for the VGA text-mode framebuffer writer:
// screen geometry defaults, control codes, and the writer FSM state type.
package vga_text_pkg;

  localparam int HTILES_DEF = 80;
  localparam int VTILES_DEF = 60;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_BLANK = 8'h20;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    CLEAR
  } state_t;

  // True for the bytes that steer the cursor instead of being written literally.
  function automatic logic is_ctrl(input logic [7:0] b);
    return (b == CH_BS) || (b == CH_LF) || (b == CH_FF) || (b == CH_CR);
  endfunction

endpackage

// File: rtl/vga_text_writer.sv
// Character stream to text framebuffer writer.
// Accepts one byte per valid/ready handshake, interprets BS/LF/FF/CR,
// writes other bytes at the cursor and advances it with column/row wrap.
// FF clears the whole screen, one blank per cycle.
// Optional: define VGA_TEXT_WRITER_LINECLR_EN to blank each newly entered row.
module vga_text_writer
  import vga_text_pkg::*;
#(
  parameter int HTILES = HTILES_DEF,
  parameter int VTILES = VTILES_DEF,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic [6:0]        o_cursor_x,
  output logic [5:0]        o_cursor_y
);

  localparam logic [ADDR_W-1:0] SCREEN_LAST = ADDR_W'(HTILES * VTILES - 1);
  localparam logic [6:0]        COL_LAST    = 7'(HTILES - 1);
  localparam logic [5:0]        ROW_LAST    = 6'(VTILES - 1);

  state_t            state;
  logic [7:0]        byte_q;
  logic [ADDR_W-1:0] clr_last;
  logic [ADDR_W-1:0] cur_addr;
  logic [5:0]        next_y;

  // row * HTILES as a shift-add over the set bits of the constant HTILES.
  function automatic logic [ADDR_W-1:0] row_base(input logic [5:0] row);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (HTILES[i]) acc = acc + (ADDR_W'(row) << i);
    end
    return acc;
  endfunction

  // Cursor-derived address and the row that a row increment lands on.
  always_comb begin
    cur_addr = ADDR_W'(o_cursor_x) + row_base(o_cursor_y);
    next_y   = (o_cursor_y == ROW_LAST) ? '0 : o_cursor_y + 6'd1;
  end

`ifdef VGA_TEXT_WRITER_LINECLR_EN
  logic [ADDR_W-1:0] nl_addr;
  logic              row_inc;

  // Start address of the new row, and whether the byte in WRITE moves to it.
  always_comb begin
    nl_addr = row_base(next_y);
    row_inc = (byte_q == CH_LF) || (!is_ctrl(byte_q) && o_cursor_x == COL_LAST);
  end
`endif

  // Writer FSM: the write strobe is registered at acceptance so it is high
  // during the WRITE cycle; the cursor moves on the WRITE exit edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      o_ready    <= 1'b1;
      o_wr_en    <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_data  <= '0;
      o_cursor_x <= '0;
      o_cursor_y <= '0;
      byte_q     <= '0;
      clr_last   <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_wr_en <= 1'b0;
          if (i_valid) begin
            byte_q  <= i_data;
            state   <= WRITE;
            o_ready <= 1'b0;
            if (i_data == CH_BS) begin
              if (o_cursor_x != '0) begin
                o_wr_en   <= 1'b1;
                o_wr_addr <= cur_addr - ADDR_W'(1);
                o_wr_data <= CH_BLANK;
              end
            end else if (!is_ctrl(i_data)) begin
              o_wr_en   <= 1'b1;
              o_wr_addr <= cur_addr;
              o_wr_data <= i_data;
            end
          end
        end

        WRITE: begin
          o_wr_en <= 1'b0;
          state   <= IDLE;
          o_ready <= 1'b1;
          case (byte_q)
            CH_LF: begin
              o_cursor_x <= '0;
              o_cursor_y <= next_y;
            end
            CH_CR: o_cursor_x <= '0;
            CH_BS: if (o_cursor_x != '0) o_cursor_x <= o_cursor_x - 7'd1;
            CH_FF: begin
              o_cursor_x <= '0;
              o_cursor_y <= '0;
              state      <= CLEAR;
              o_ready    <= 1'b0;
              o_wr_en    <= 1'b1;
              o_wr_addr  <= '0;
              o_wr_data  <= CH_BLANK;
              clr_last   <= SCREEN_LAST;
            end
            default: begin
              if (o_cursor_x == COL_LAST) begin
                o_cursor_x <= '0;
                o_cursor_y <= next_y;
              end else begin
                o_cursor_x <= o_cursor_x + 7'd1;
              end
            end
          endcase
`ifdef VGA_TEXT_WRITER_LINECLR_EN
          if (row_inc) begin
            state     <= CLEAR;
            o_ready   <= 1'b0;
            o_wr_en   <= 1'b1;
            o_wr_addr <= nl_addr;
            o_wr_data <= CH_BLANK;
            clr_last  <= nl_addr + ADDR_W'(HTILES - 1);
          end
`endif
        end

        CLEAR: begin
          if (o_wr_addr == clr_last) begin
            o_wr_en <= 1'b0;
            state   <= IDLE;
            o_ready <= 1'b1;
          end else begin
            o_wr_addr <= o_wr_addr + ADDR_W'(1);
          end
        end

        default: begin
          state   <= IDLE;
          o_ready <= 1'b1;
          o_wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
